// File: rtl/hamming_pkg.sv
// Shared types and widths for the Hamming(7,4) scrubbed register store.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hamming_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOST_RD  = 2'd1,
        SCRUB_RD = 2'd2,
        SCRUB_WB = 2'd3
    } state_t;

endpackage

// File: rtl/hamming74_decoder.sv
// Hamming(7,4) decoder with single-bit correction; layout matches hamming74_encoder.
// Latency: combinational.
// Backpressure: none.
// Ports: code (7-bit) -> data (corrected), error_detected, error_corrected.
module hamming74_decoder
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W-1:0] data,
    output logic              error_detected,
    output logic              error_corrected
);

    logic [2:0]        syn;
    logic [CODE_W-1:0] fixed;

    assign syn[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
    assign syn[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
    assign syn[2] = code[3] ^ code[4] ^ code[5] ^ code[6];

    // A non-zero syndrome names the 1-based position of the flipped bit.
    always_comb begin
        fixed = code;
        if (syn != 3'd0) begin
            fixed[syn - 3'd1] = ~code[syn - 3'd1];
        end
    end

    // Plain (7,4) has no extra parity: every non-zero syndrome is treated as correctable.
    assign error_detected  = (syn != 3'd0);
    assign error_corrected = (syn != 3'd0);
    assign data            = {fixed[6], fixed[5], fixed[4], fixed[2]};

endmodule

// File: rtl/hamming74_encoder.sv
// Hamming(7,4) encoder: code[i] holds codeword position i+1 (p1 p2 d1 p3 d2 d3 d4).
// Latency: combinational.
// Backpressure: none.
// Ports: data (4-bit payload) -> code (7-bit codeword).
module hamming74_encoder
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CODE_W-1:0] code
);

    assign code[0] = data[0] ^ data[1] ^ data[3];
    assign code[1] = data[0] ^ data[2] ^ data[3];
    assign code[2] = data[0];
    assign code[3] = data[1] ^ data[2] ^ data[3];
    assign code[4] = data[1];
    assign code[5] = data[2];
    assign code[6] = data[3];

endmodule

// File: rtl/hamming_scrub_timer.sv
// Scrub interval timer with pending flag and host-starvation guard.
// Latency: pending rises on the edge where the timer wraps; cleared when a scrub starts.
// Backpressure: starve_block asks the controller to refuse host requests until the scrub runs.
// Ports: clk, rst, scrub_en, host_accept, scrub_start -> scrub_pending, starve_block.
module hamming_scrub_timer #(
    parameter int SCRUB_INTERVAL = 256,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic scrub_en,
    input  logic host_accept,
    input  logic scrub_start,
    output logic scrub_pending,
    output logic starve_block
);

    localparam int TW = $clog2(SCRUB_INTERVAL);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(SCRUB_INTERVAL - 1);
    localparam logic [SW-1:0] S_MAX  = SW'(STARVE_LIMIT);

    logic [TW-1:0] timer;
    logic [SW-1:0] starve_cnt;
    logic          expire;

    assign expire       = scrub_en && (timer == T_LAST);
    assign starve_block = scrub_pending && (starve_cnt >= S_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            timer         <= '0;
            scrub_pending <= 1'b0;
            starve_cnt    <= '0;
        end else begin
            if (scrub_en) begin
                timer <= expire ? '0 : timer + 1'b1;
            end
            // An expiry while already pending is simply absorbed.
            if (scrub_start) begin
                scrub_pending <= 1'b0;
            end else if (expire) begin
                scrub_pending <= 1'b1;
            end
            if (scrub_start) begin
                starve_cnt <= '0;
            end else if (scrub_pending && host_accept && (starve_cnt < S_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// ECC register store controller: host read/write port arbitrated against a background scrubber.
// Latency: host read response one cycle after the accepting edge; writes commit at the accepting edge.
// Backpressure: req_ready low outside IDLE and while a starved scrub is forcing its turn.
// Ports: clk, rst; host req_* / rsp_*; scrub_en; corr_cnt, uncorr_cnt, busy.
// Optional: HAMMING_ERR_INJECT_EN adds inject_mask, XORed into every stored host write.
module hamming_scrub_ctrl
    import hamming_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4,
    parameter int SCRUB_INTERVAL = 256,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err_corr,
    output logic              rsp_err_uncorr,
    input  logic              scrub_en,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt,
    output logic              busy
`ifdef HAMMING_ERR_INJECT_EN
    ,
    input  logic [CODE_W-1:0] inject_mask
`endif
);

    state_t            state, state_nxt;
    logic [CODE_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] scrub_ptr, dec_addr;
    logic [CODE_W-1:0] wr_code_raw, wr_code, wb_code, dec_code;
    logic [DATA_W-1:0] dec_data;
    logic              dec_det, dec_fix, corr, uncorr;
    logic              scrub_pending, starve_block;
    logic              host_accept, scrub_start, scrub_side, ptr_adv;
    logic              corr_inc, uncorr_inc;

    assign req_ready   = (state == IDLE) && !starve_block;
    assign host_accept = req_valid && req_ready;
    assign busy        = (state != IDLE);

    // One decoder serves both sides: host reads decode at the accepting edge (IDLE),
    // the scrubber owns the port in SCRUB_RD/SCRUB_WB.
    assign scrub_side = (state == SCRUB_RD) || (state == SCRUB_WB);
    assign dec_addr   = scrub_side ? scrub_ptr : req_addr;
    assign dec_code   = mem[dec_addr];

    hamming74_encoder u_enc_wr (.data(req_wdata), .code(wr_code_raw));
    hamming74_decoder u_dec (
        .code           (dec_code),
        .data           (dec_data),
        .error_detected (dec_det),
        .error_corrected(dec_fix)
    );
    // SCRUB_WB re-decodes the still-unmodified word, so the corrected data needs no register.
    hamming74_encoder u_enc_wb (.data(dec_data), .code(wb_code));

`ifdef HAMMING_ERR_INJECT_EN
    assign wr_code = wr_code_raw ^ inject_mask;
`else
    assign wr_code = wr_code_raw;
`endif

    assign corr   = dec_fix;
    assign uncorr = dec_det & ~dec_fix;

    hamming_scrub_timer #(
        .SCRUB_INTERVAL(SCRUB_INTERVAL),
        .STARVE_LIMIT  (STARVE_LIMIT)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .scrub_en     (scrub_en),
        .host_accept  (host_accept),
        .scrub_start  (scrub_start),
        .scrub_pending(scrub_pending),
        .starve_block (starve_block)
    );

    always_comb begin
        state_nxt   = state;
        scrub_start = 1'b0;
        ptr_adv     = 1'b0;
        case (state)
            IDLE: begin
                if (host_accept) begin
                    if (!req_we) state_nxt = HOST_RD;
                end else if (scrub_pending) begin
                    state_nxt   = SCRUB_RD;
                    scrub_start = 1'b1;
                end
            end
            HOST_RD: state_nxt = IDLE;
            SCRUB_RD: begin
                if (corr) begin
                    state_nxt = SCRUB_WB;
                end else begin
                    state_nxt = IDLE;
                    ptr_adv   = 1'b1;
                end
            end
            SCRUB_WB: begin
                state_nxt = IDLE;
                ptr_adv   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Host and scrub events live in different states, so at most one increment per cycle.
    assign corr_inc   = ((state == HOST_RD) && rsp_err_corr)   || ((state == SCRUB_RD) && corr);
    assign uncorr_inc = ((state == HOST_RD) && rsp_err_uncorr) || ((state == SCRUB_RD) && uncorr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            scrub_ptr      <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err_corr   <= 1'b0;
            rsp_err_uncorr <= 1'b0;
            corr_cnt       <= '0;
            uncorr_cnt     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            rsp_valid <= host_accept && !req_we;
            if (host_accept && !req_we) begin
                rsp_rdata      <= dec_data;
                rsp_err_corr   <= corr;
                rsp_err_uncorr <= uncorr;
            end
            if (host_accept && req_we) begin
                mem[req_addr] <= wr_code;
            end
            if (state == SCRUB_WB) begin
                mem[scrub_ptr] <= wb_code;
            end
            if (ptr_adv) begin
                scrub_ptr <= scrub_ptr + 1'b1;
            end
            if (corr_inc && (corr_cnt != '1)) begin
                corr_cnt <= corr_cnt + 1'b1;
            end
            if (uncorr_inc && (uncorr_cnt != '1)) begin
                uncorr_cnt <= uncorr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/hamming_scrub_ctrl.md
Name: hamming_scrub_ctrl

Overview:
Controller for a small ECC-protected register store built on the existing Hamming(7,4) encoder/decoder pair. It arbitrates a host read/write port against a background scrubber.
- Writes are encoded before storage.
- Host reads are decoded and corrected on the fly.
- The scrubber periodically walks every word and writes back single-bit-corrected codewords.
- Correctable and uncorrectable events are counted for status.

Parameters:
- DEPTH, 16, number of 7-bit codeword entries; must be a power of two.
- ADDR_W, 4, address width; equals log2(DEPTH).
- SCRUB_INTERVAL, 256, cycles between scrub steps (minimum 2).
- STARVE_LIMIT, 8, cycles a pending scrub may be deferred by the host before host requests are blocked.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  controller can accept a host request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  entry address.
- req_wdata  in  4  write data.
- rsp_valid  out  1  read response valid (one-cycle pulse).
- rsp_rdata  out  4  corrected read data.
- rsp_err_corr  out  1  single-bit error corrected in this response.
- rsp_err_uncorr  out  1  uncorrectable error in this response.
- scrub_en  in  1  enables the scrub timer.
- corr_cnt  out  16  saturating count of corrected errors (host and scrub).
- uncorr_cnt  out  16  saturating count of uncorrectable errors.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state IDLE; all memory entries = 7'b0000000 (valid codeword for data 0).
  - scrub_ptr, timer, starve counter, corr_cnt, uncorr_cnt = 0; scrub_pending = 0.
  - rsp_valid, rsp_err_corr, rsp_err_uncorr, rsp_rdata, busy = 0.
  - Reset asserted in any state aborts the operation in progress. A scrub writeback not yet committed is dropped.
- Error classification from the decoder outputs:
  - corr = error_corrected.
  - uncorr = error_detected & ~error_corrected.
- Timer:
  - Counts only while scrub_en = 1; holds its value when scrub_en = 0.
  - When it reaches SCRUB_INTERVAL-1: wraps to 0 and sets scrub_pending.
  - A new expiry while scrub_pending is already set is absorbed (no queueing).
- req_ready = (state == IDLE) & ~(scrub_pending & starve_cnt >= STARVE_LIMIT).
- FSM states: IDLE, HOST_RD, SCRUB_RD, SCRUB_WB.
- IDLE:
  - Host handshake takes priority when req_ready is high.
  - Write accept: mem[req_addr] <= encode(req_wdata) at the accepting edge. No response is generated. Stay in IDLE.
  - Read accept: latch the address and go to HOST_RD.
  - Otherwise, if scrub_pending is set, go to SCRUB_RD and clear scrub_pending and starve_cnt.
  - starve_cnt increments (saturating) each cycle scrub_pending is set and a host request is accepted instead.
- HOST_RD:
  - Decode mem[addr].
  - Register rsp_rdata, rsp_err_corr and rsp_err_uncorr, and pulse rsp_valid.
  - rsp_valid is high exactly one cycle, the cycle after the accepting edge (latency 1).
  - No writeback. Counters update. Return to IDLE.
- SCRUB_RD:
  - Decode mem[scrub_ptr].
  - corr: go to SCRUB_WB and increment corr_cnt.
  - uncorr: increment uncorr_cnt, no writeback, advance ptr, return to IDLE.
  - Clean: advance ptr, return to IDLE.
- SCRUB_WB:
  - mem[scrub_ptr] <= encode(corrected data).
  - Advance ptr; it wraps from DEPTH-1 to 0. Return to IDLE.
- Counters saturate at 16'hFFFF. At most one increment per cycle.
- Host and scrub accesses can never target memory in the same cycle, because req_ready is low outside IDLE.

Optional Feature:
- HAMMING_ERR_INJECT_EN defined:
  - Adds input port inject_mask[6:0].
  - Each accepted host write stores encode(req_wdata) ^ inject_mask.
- Not defined: no port; the stored value is always the clean codeword.

Decomposition:
- Package hamming_pkg holds:
  - CODE_W=7 and DATA_W=4;
  - the state enum typedef (IDLE, HOST_RD, SCRUB_RD, SCRUB_WB);
  - the counter width constant (16).
- Reuse the existing hamming74_encoder (two instances: write path and scrub writeback) and hamming74_decoder (one, shared via an address mux).
- One natural sub-module: hamming_scrub_timer, which holds the interval counter and the pending/starve logic.

Test Plan:
1. Write 4'b1011 to addr 3, then read addr 3 → rsp_valid exactly 1 cycle after accept, rsp_rdata=1011, both error flags 0, counters 0.
2. With HAMMING_ERR_INJECT_EN, write 1011 to addr 5 with inject_mask=7'b0001000, then read → rsp_rdata=1011, rsp_err_corr=1, corr_cnt=1.
3. Same corrupted word, SCRUB_INTERVAL=4, scrub_en=1, run until ptr passes 5 → corr_cnt=2 and SCRUB_WB visited once. A following read gives rsp_rdata=1011 with rsp_err_corr=0.
4. inject_mask=7'b0001100 (two flips) → rsp_err_corr|rsp_err_uncorr=1. Whichever counter the flags select increments by 1. A scrub of that word never writes back when uncorr is set.
5. Hold req_valid high continuously with reads while a scrub is pending, STARVE_LIMIT=8 → exactly 8 host reads accepted, then req_ready=0 and SCRUB_RD entered the next cycle.
6. Assert rst in SCRUB_RD → next cycle: state IDLE, outputs and counters 0, scrub_ptr 0, memory reads back data 0.
